acc_drain_ctrl: RTL and testbench
=================================

# acc_drain_ctrl

Feeder and drain controller for one `mac_unit`. Accepts an operand stream (activation/weight pairs with a last marker) and drives the MAC's `data_in`/`weight_in`/`enable`. At the end of each dot product it captures the 32-bit accumulator and pulses `clear_acc`. It then requantizes the captured value to INT8 (scale multiply, rounding right shift, zero-point add, saturation) and presents the result on a valid/ready output toward the activation buffer.

## Interface
Parameters:
- `ACC_WIDTH`, 32: MAC accumulator width.
- `IN_WIDTH`, 8: activation/weight width.
- `OUT_WIDTH`, 8: requantized output width.
- `SCALE_WIDTH`, 16: unsigned multiplier width.
- `SHIFT_WIDTH`, 6: right-shift amount width; valid range 0..47.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  operand beat accepted when high with `in_valid`.
- `in_data`  in  IN_WIDTH  activation, signed.
- `in_weight`  in  IN_WIDTH  weight, signed.
- `in_last`  in  1  final beat of the current dot product.
- `cfg_scale`  in  SCALE_WIDTH  unsigned multiplier.
- `cfg_shift`  in  SHIFT_WIDTH  rounding right shift.
- `cfg_zp`  in  OUT_WIDTH  signed zero point.
- `mac_enable`  out  1  to MAC `enable`.
- `mac_clear_acc`  out  1  to MAC `clear_acc`.
- `mac_data_in`  out  IN_WIDTH  to MAC `data_in`.
- `mac_weight_in`  out  IN_WIDTH  to MAC `weight_in`.
- `mac_acc`  in  ACC_WIDTH  from MAC `data_out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  OUT_WIDTH  signed INT8 result.
- `busy`  out  1  high in any state other than ACCUM.

## Operation
- FSM states: ACCUM, CAPTURE, MUL, SAT, OUT. Reset state is ACCUM.
- ACCUM:
  - `in_ready`=1.
  - `mac_enable` = `in_valid & in_ready`, combinational.
  - `mac_data_in`/`mac_weight_in` are a combinational pass-through of `in_data`/`in_weight`.
  - An accepted beat with `in_last`=1 moves the FSM to CAPTURE.
- CAPTURE:
  - `in_ready`=0.
  - `acc_q <= mac_acc`.
  - `cfg_scale`/`cfg_shift`/`cfg_zp` are sampled into registers.
  - `mac_clear_acc`=1 for exactly this cycle; it is a registered output, high only in CAPTURE.
  - Next state: MUL.
- MUL: `prod_q <= acc_q * {1'b0, scale_q}`, a signed product of ACC_WIDTH+SCALE_WIDTH+1 = 49 bits. Next state: SAT.
- SAT:
  - If shift = 0, `r = prod_q`.
  - Otherwise, `r = (prod_q + (1 << (shift-1))) >>> shift`. This is round-half-up; the add is done at 50 bits so it cannot overflow.
  - `v = r + sign_extend(zp)`.
  - Clamp `v` to [-128, 127]; the result goes to `out_data`.
  - Set `out_valid` <= 1. Next state: OUT.
- OUT: hold `out_data` stable. On `out_valid & out_ready`, clear `out_valid` and go to ACCUM.
- No beat is accepted outside ACCUM. `in_valid` held high during CAPTURE..OUT simply waits.
- A single-beat dot product (`in_last` on the first beat) is legal.
- Reset, at any time including mid-dot-product:
  - FSM returns to ACCUM.
  - `out_valid`=0, `out_data`=0, `mac_clear_acc`=0, `acc_q`/`prod_q`=0.
  - The MAC shares `rst_n`, so the partial sum is discarded.

## Timing
- Last beat accepted in cycle t:
  - MAC accumulator updated at the end of t.
  - CAPTURE in t+1; `mac_clear_acc` high in t+1.
  - MUL in t+2; SAT in t+3.
  - `out_valid` high from t+4.
- Earliest next beat: the cycle after the output handshake.
- Minimum period is K+4 cycles per K-beat dot product with `out_ready` held high.
- Reset values: `in_ready`=1 combinationally once out of reset. All other outputs are 0.

## Structure
- Shared package `npu_pkg`:
  - `acc_drain_state_e` enum.
  - `INT8_MIN`/`INT8_MAX` constants.
  - Default width localparams matching `mac_unit`.
- Sub-module `requant_core`: holds the MUL and SAT stages. It has a 2-stage pipeline with an enable per stage, and exposes the registered product and the saturation result. The FSM stays in `acc_drain_ctrl`.

## Test plan
- Basic dot product:
  - Stimulus: 4 beats of (2,3), last on beat 4; scale=1, shift=0, zp=0.
  - Required: `out_data`=24 at t+4; `mac_clear_acc` high exactly at t+1; next dot product starts from 0.
- Saturation:
  - Positive stimulus: 4 beats (127,127), scale=1, shift=0 → 127.
  - Negative stimulus: 4 beats (-128,127) → -128.
- Rounding:
  - acc=5, scale=1, shift=1 → 3.
  - acc=-5, scale=1, shift=1 → -2.
  - acc=100, scale=3, shift=2, zp=-10 → 65.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 6 cycles after `out_valid` rises, with `in_valid` held high.
  - Required: `out_data` stable; `in_ready`=0; `mac_enable`=0 throughout; the next beat is accepted the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 after 2 of 4 beats, then restart with 1 beat (1,1).
  - Required: `out_data`=1 and no stale output.
- Config sampling:
  - Stimulus: change `cfg_scale` from 2 to 7 in the cycle after CAPTURE; acc=10, shift=0.
  - Required: `out_data`=20.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths matching mac_unit, INT8 limits, drain FSM states.
package npu_pkg;
    localparam int ACC_W   = 32;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 6;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    typedef enum logic [2:0] {
        ACCUM,
        CAPTURE,
        MUL,
        SAT,
        OUT
    } acc_drain_state_e;
endpackage

// File: rtl/acc_drain_ctrl_if.sv
// Operand stream in and requantized result out, both valid/ready; master is the producer/consumer side.
interface acc_drain_ctrl_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic [IN_WIDTH-1:0]  in_weight;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_weight, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_weight, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/requant_core.sv
// Requantizer: scale multiply (stage 1), round/shift/zero-point/saturate into a held result (stage 2).
// One cycle per stage, each advanced only by its enable; no backpressure of its own.
module requant_core
    import npu_pkg::*;
#(
    parameter  int ACC_WIDTH   = ACC_W,
    parameter  int SCALE_WIDTH = SCALE_W,
    parameter  int SHIFT_WIDTH = SHIFT_W,
    parameter  int OUT_WIDTH   = OUT_W,
    localparam int PROD_W      = ACC_WIDTH + SCALE_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mul_en,
    input  logic                        sat_en,
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic [SCALE_WIDTH-1:0]      scale,
    input  logic [SHIFT_WIDTH-1:0]      shift,
    input  logic signed [OUT_WIDTH-1:0] zp,
    output logic signed [PROD_W-1:0]    prod_q,
    output logic signed [OUT_WIDTH-1:0] out_q
);
    localparam int RND_W = PROD_W + 1;
    localparam int SUM_W = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(INT8_MAX);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(INT8_MIN);

    logic signed [RND_W-1:0]     rnd_sum;
    logic signed [RND_W-1:0]     rnd_shr;
    logic signed [SUM_W-1:0]     zp_sum;
    logic signed [OUT_WIDTH-1:0] sat_dat;

    // One extra bit keeps the half-LSB rounding add from overflowing.
    always_comb begin
        rnd_sum = RND_W'(prod_q);
        if (shift != '0) begin
            rnd_sum = rnd_sum + (RND_W'(1) << (shift - SHIFT_WIDTH'(1)));
        end
        rnd_shr = rnd_sum >>> shift;
        zp_sum  = SUM_W'(rnd_shr) + SUM_W'(zp);
        if (zp_sum > SAT_MAX) begin
            sat_dat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (zp_sum < SAT_MIN) begin
            sat_dat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat_dat = zp_sum[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            out_q  <= '0;
        end else begin
            if (mul_en) begin
                prod_q <= PROD_W'(acc) * PROD_W'($signed({1'b0, scale}));
            end
            if (sat_en) begin
                out_q <= sat_dat;
            end
        end
    end
endmodule

// File: rtl/acc_drain_ctrl.sv
// Feeds operand beats to one mac_unit, drains and clears its accumulator, emits a requantized INT8 result.
// Result valid 4 cycles after the last beat; no beat is accepted until the result is taken downstream.
module acc_drain_ctrl
    import npu_pkg::*;
#(
    parameter  int ACC_WIDTH   = ACC_W,
    parameter  int IN_WIDTH    = IN_W,
    parameter  int OUT_WIDTH   = OUT_W,
    parameter  int SCALE_WIDTH = SCALE_W,
    parameter  int SHIFT_WIDTH = SHIFT_W,
    localparam int PROD_W      = ACC_WIDTH + SCALE_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    acc_drain_ctrl_if.slave        io,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [OUT_WIDTH-1:0]   cfg_zp,
    output logic                   mac_enable,
    output logic                   mac_clear_acc,
    output logic [IN_WIDTH-1:0]    mac_data_in,
    output logic [IN_WIDTH-1:0]    mac_weight_in,
    input  logic [ACC_WIDTH-1:0]   mac_acc,
    output logic                   busy
);
    acc_drain_state_e state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [SCALE_WIDTH-1:0]      scale_q;
    logic [SHIFT_WIDTH-1:0]      shift_q;
    logic signed [OUT_WIDTH-1:0] zp_q;
    logic                        out_valid_q;
    logic                        beat_acc;
    logic signed [PROD_W-1:0]    prod_unused;

    always_comb begin
        state_nxt   = state;
        io.in_ready = (state == ACCUM);
        beat_acc    = io.in_valid && io.in_ready;
        case (state)
            ACCUM:   if (beat_acc && io.in_last) state_nxt = CAPTURE;
            CAPTURE: state_nxt = MUL;
            MUL:     state_nxt = SAT;
            SAT:     state_nxt = OUT;
            OUT:     if (out_valid_q && io.out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    assign mac_enable    = beat_acc;
    assign mac_data_in   = io.in_data;
    assign mac_weight_in = io.in_weight;
    assign busy          = (state != ACCUM);
    assign io.out_valid  = out_valid_q;

    // Config is frozen at CAPTURE so a mid-requant change cannot mix two settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            mac_clear_acc <= 1'b0;
            out_valid_q   <= 1'b0;
            acc_q         <= '0;
            scale_q       <= '0;
            shift_q       <= '0;
            zp_q          <= '0;
        end else begin
            state         <= state_nxt;
            mac_clear_acc <= (state_nxt == CAPTURE);
            if (state == CAPTURE) begin
                acc_q   <= $signed(mac_acc);
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
                zp_q    <= $signed(cfg_zp);
            end
            if (state == SAT) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && io.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    requant_core #(
        .ACC_WIDTH  (ACC_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_requant (
        .clk   (clk),
        .rst_n (rst_n),
        .mul_en(state == MUL),
        .sat_en(state == SAT),
        .acc   (acc_q),
        .scale (scale_q),
        .shift (shift_q),
        .zp    (zp_q),
        .prod_q(prod_unused),
        .out_q (io.out_data)
    );
endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed bench for acc_drain_ctrl with a behavioural mac_unit model driving mac_acc.
module tb_acc_drain_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_scale;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        mac_enable;
    logic        mac_clear_acc;
    logic [7:0]  mac_data_in;
    logic [7:0]  mac_weight_in;
    logic [31:0] mac_acc;
    logic        busy;

    int passed = 0;
    int total  = 0;

    acc_drain_ctrl_if #(.IN_WIDTH(8), .OUT_WIDTH(8)) io ();

    acc_drain_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io           (io),
        .cfg_scale    (cfg_scale),
        .cfg_shift    (cfg_shift),
        .cfg_zp       (cfg_zp),
        .mac_enable   (mac_enable),
        .mac_clear_acc(mac_clear_acc),
        .mac_data_in  (mac_data_in),
        .mac_weight_in(mac_weight_in),
        .mac_acc      (mac_acc),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire signed [31:0] mac_prod = $signed(mac_data_in) * $signed(mac_weight_in);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             mac_acc <= '0;
        else if (mac_clear_acc) mac_acc <= '0;
        else if (mac_enable)    mac_acc <= mac_acc + mac_prod;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input logic [15:0] s, input logic [5:0] sh, input logic [7:0] z);
        cfg_scale = s;
        cfg_shift = sh;
        cfg_zp    = z;
    endtask

    task automatic feed_beat(input logic [7:0] a, input logic [7:0] w, input logic last);
        io.in_valid  = 1'b1;
        io.in_data   = a;
        io.in_weight = w;
        io.in_last   = last;
        @(posedge clk); #1;
        io.in_valid  = 1'b0;
        io.in_last   = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!io.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_dot(input int n, input logic [7:0] a, input logic [7:0] w, output int cyc);
        for (int i = 0; i < n; i++) feed_beat(a, w, i == n - 1);
        wait_valid(cyc);
    endtask

    task automatic take_out();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (io.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", io.out_valid); else passed++;
        total++; if (io.out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", io.out_data); else passed++;
        total++; if (mac_clear_acc !== 1'b0) $display("FAIL reset_clear got %b want 0", mac_clear_acc); else passed++;
        total++; if (mac_enable !== 1'b0) $display("FAIL reset_enable got %b want 0", mac_enable); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++; if (io.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", io.in_ready); else passed++;
    endtask

    task automatic test_basic();
        int cyc;
        set_cfg(16'd1, 6'd0, 8'd0);
        for (int i = 0; i < 3; i++) feed_beat(8'd2, 8'd3, 1'b0);
        total++; if (mac_clear_acc !== 1'b0) $display("FAIL basic_clear_early got %b want 0", mac_clear_acc); else passed++;
        feed_beat(8'd2, 8'd3, 1'b1);
        total++; if (mac_clear_acc !== 1'b1) $display("FAIL basic_clear_t1 got %b want 1", mac_clear_acc); else passed++;
        total++; if (io.in_ready !== 1'b0) $display("FAIL basic_in_ready_capture got %b want 0", io.in_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
        @(posedge clk); #1;
        total++; if (mac_clear_acc !== 1'b0) $display("FAIL basic_clear_t2 got %b want 0", mac_clear_acc); else passed++;
        wait_valid(cyc);
        total++; if (cyc !== 2) $display("FAIL basic_latency got %0d want 2 more cycles", cyc); else passed++;
        total++; if (io.out_data !== 8'd24) $display("FAIL basic_out got %0d want 24", $signed(io.out_data)); else passed++;
        take_out();
        total++; if (io.out_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", io.out_valid); else passed++;
        run_dot(1, 8'd1, 8'd5, cyc);
        total++; if (cyc !== 3) $display("FAIL basic_single_latency got %0d want 3", cyc); else passed++;
        total++; if (io.out_data !== 8'd5) $display("FAIL basic_fresh_sum got %0d want 5", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    task automatic test_saturation();
        int cyc;
        set_cfg(16'd1, 6'd0, 8'd0);
        run_dot(4, 8'd127, 8'd127, cyc);
        total++; if (io.out_data !== 8'h7F) $display("FAIL sat_pos got %0d want 127", $signed(io.out_data)); else passed++;
        take_out();
        run_dot(4, 8'h80, 8'd127, cyc);
        total++; if (io.out_data !== 8'h80) $display("FAIL sat_neg got %0d want -128", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    task automatic test_rounding();
        int cyc;
        set_cfg(16'd1, 6'd1, 8'd0);
        run_dot(1, 8'd5, 8'd1, cyc);
        total++; if (io.out_data !== 8'd3) $display("FAIL round_pos got %0d want 3", $signed(io.out_data)); else passed++;
        take_out();
        run_dot(1, 8'hFB, 8'd1, cyc);
        total++; if (io.out_data !== 8'hFE) $display("FAIL round_neg got %0d want -2", $signed(io.out_data)); else passed++;
        take_out();
        set_cfg(16'd3, 6'd2, 8'hF6);
        run_dot(1, 8'd100, 8'd1, cyc);
        total++; if (io.out_data !== 8'd65) $display("FAIL round_zp got %0d want 65", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    task automatic test_backpressure();
        int cyc;
        set_cfg(16'd1, 6'd0, 8'd0);
        io.out_ready = 1'b0;
        run_dot(1, 8'd3, 8'd3, cyc);
        total++; if (io.out_data !== 8'd9) $display("FAIL bp_first got %0d want 9", $signed(io.out_data)); else passed++;
        io.in_valid  = 1'b1;
        io.in_data   = 8'd7;
        io.in_weight = 8'd1;
        io.in_last   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++; if (io.out_data !== 8'd9) $display("FAIL bp_hold[%0d] got %0d want 9", i, $signed(io.out_data)); else passed++;
            total++; if (io.in_ready !== 1'b0 || mac_enable !== 1'b0)
                $display("FAIL bp_stall[%0d] in_ready=%b mac_enable=%b want 0/0", i, io.in_ready, mac_enable); else passed++;
            @(posedge clk); #1;
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (mac_enable !== 1'b1) $display("FAIL bp_next_accept got %b want 1", mac_enable); else passed++;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
        wait_valid(cyc);
        total++; if (io.out_data !== 8'd7) $display("FAIL bp_second got %0d want 7", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_cfg(16'd1, 6'd0, 8'd0);
        feed_beat(8'd2, 8'd3, 1'b0);
        feed_beat(8'd2, 8'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (io.out_data !== 8'd0 || io.out_valid !== 1'b0)
            $display("FAIL rst_mid_outputs data=%0d valid=%b want 0/0", $signed(io.out_data), io.out_valid); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_dot(1, 8'd1, 8'd1, cyc);
        total++; if (cyc !== 3) $display("FAIL rst_mid_latency got %0d want 3", cyc); else passed++;
        total++; if (io.out_data !== 8'd1) $display("FAIL rst_mid_result got %0d want 1", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    task automatic test_cfg_sample();
        int cyc;
        set_cfg(16'd2, 6'd0, 8'd0);
        feed_beat(8'd10, 8'd1, 1'b1);
        @(posedge clk); #1;
        cfg_scale = 16'd7;
        wait_valid(cyc);
        total++; if (io.out_data !== 8'd20) $display("FAIL cfg_sample got %0d want 20", $signed(io.out_data)); else passed++;
        take_out();
    endtask

    initial begin
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.in_weight = '0;
        io.in_last   = 1'b0;
        io.out_ready = 1'b1;
        set_cfg(16'd0, 6'd0, 8'd0);
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        test_cfg_sample();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
